mux_scan_ctrl: RTL and testbench

Scan controller that sits around the buffered 4-to-1 mux (`max_4to1`). Upstream, it drives the mux select lines `I0`/`I1` through all four channels. Downstream, it samples the mux output `Q` once per channel after a programmable settling delay. It then presents the four sampled bits as one parallel word with a single-cycle valid strobe. It converts the bit-serial, select-addressed mux path back into a registered 4-bit snapshot of `d1..d4`.

---
 rtl/mux_scan_ctrl.sv | 109 ++++++++++
 tb/tb_mux_scan_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_ctrl.sv
// Scan controller for a buffered 4-to-1 mux: steps the select lines through all
// four channels, samples Q after a settling delay and publishes a 4-bit snapshot.
module mux_scan_ctrl #(
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       Q,
  output logic       I0,
  output logic       I1,
  output logic       busy,
  output logic [3:0] word,
  output logic       valid
);

  // state    | meaning
  // S_IDLE   | select parked at 00, waiting for start
  // S_SETTLE | holding select while the mux output settles
  // S_SAMPLE | capturing Q for the current channel
  // S_DONE   | snapshot published, valid pulses for one cycle
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

  state_t     state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] shreg_q, shreg_d;
  logic [3:0] word_q, word_d;
  logic       busy_q, busy_d;
  logic       valid_q, valid_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sel_q   <= 2'd0;
      cnt_q   <= 4'd0;
      shreg_q <= 4'd0;
      word_q  <= 4'd0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      word_q  <= word_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_SETTLE;
      S_SETTLE: if (cnt_q == CNT_LAST) state_d = S_SAMPLE;
      S_SAMPLE: state_d = (sel_q == 2'd3) ? S_DONE : S_SETTLE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath next values; busy/valid are decoded from the next state so they
  // come out of flops aligned with the state they describe.
  always_comb begin
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    word_d  = word_q;
    case (state_q)
      S_IDLE: begin
        sel_d = 2'd0;
        if (start) begin
          cnt_d   = 4'd0;
          shreg_d = 4'd0;
        end
      end
      S_SETTLE: cnt_d = cnt_q + 4'd1;
      S_SAMPLE: begin
        shreg_d[sel_q] = Q;
        cnt_d = 4'd0;
        if (sel_q == 2'd3) begin
          sel_d  = 2'd0;
          word_d = shreg_d;
        end else begin
          sel_d = sel_q + 2'd1;
        end
      end
      S_DONE:  sel_d = 2'd0;
      default: sel_d = 2'd0;
    endcase
    busy_d  = (state_d != S_IDLE);
    valid_d = (state_d == S_DONE);
  end

  assign I0    = sel_q[0];
  assign I1    = sel_q[1];
  assign busy  = busy_q;
  assign word  = word_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: one SETTLE=2 instance for most scenarios and
// one SETTLE=1 instance for the continuous-start case, each with a behavioural mux.
module tb_mux_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b1;
  logic [3:0] d_vec = 4'b0000;
  logic       q, i0, i1, busy, valid;
  logic [3:0] word;

  logic       rst2 = 1'b1;
  logic       start2 = 1'b0;
  logic [3:0] d2_vec = 4'b0000;
  logic       q2, i0_2, i1_2, busy2, valid2;
  logic [3:0] word2;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  assign q  = d_vec[{i1, i0}];
  assign q2 = d2_vec[{i1_2, i0_2}];

  mux_scan_ctrl #(.SETTLE(2)) dut (
    .clk(clk), .rst(rst), .start(start), .Q(q),
    .I0(i0), .I1(i1), .busy(busy), .word(word), .valid(valid)
  );

  mux_scan_ctrl #(.SETTLE(1)) dut2 (
    .clk(clk), .rst(rst2), .start(start2), .Q(q2),
    .I0(i0_2), .I1(i1_2), .busy(busy2), .word(word2), .valid(valid2)
  );

  // Leaves the caller at the negedge of cycle 1 after the edge that takes start.
  task automatic kick();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++; if ({i1, i0} !== 2'b00) $display("FAIL reset_sel got %b want 00", {i1, i0}); else passes++;
      checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passes++;
      checks++; if (valid !== 1'b0) $display("FAIL reset_valid got %b want 0", valid); else passes++;
      checks++; if (word !== 4'b0000) $display("FAIL reset_word got %b want 0000", word); else passes++;
    end
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) $display("FAIL reset_release_busy got %b want 0", busy); else passes++;
    checks++; if (word2 !== 4'b0000) $display("FAIL reset_dut2_word got %b want 0000", word2); else passes++;
  endtask

  task automatic test_basic();
    logic [1:0] exp_sel [14] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2,
                                 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0, 2'd0};
    d_vec = 4'b0101;
    kick();
    for (int c = 1; c <= 14; c++) begin
      checks++;
      if ({i1, i0} !== exp_sel[c-1])
        $display("FAIL basic_sel cycle %0d got %b want %b", c, {i1, i0}, exp_sel[c-1]);
      else passes++;
      checks++;
      if (busy !== 1'(c <= 13)) $display("FAIL basic_busy cycle %0d got %b want %b", c, busy, c <= 13);
      else passes++;
      checks++;
      if (valid !== 1'(c == 13)) $display("FAIL basic_valid cycle %0d got %b want %b", c, valid, c == 13);
      else passes++;
      if (c == 13) begin
        checks++;
        if (word !== 4'b0101) $display("FAIL basic_word got %b want 0101", word); else passes++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_word_hold();
    int nv = 0;
    d_vec = 4'b1110;
    kick();
    for (int c = 1; c <= 14; c++) begin
      if (valid === 1'b1) nv++;
      @(negedge clk);
    end
    checks++; if (nv != 1) $display("FAIL hold_scan_valids got %0d want 1", nv); else passes++;
    checks++; if (word !== 4'b1110) $display("FAIL hold_scan_word got %b want 1110", word); else passes++;
    d_vec = 4'b1111;
    for (int c = 0; c < 20; c++) begin
      if (valid === 1'b1) nv++;
      @(negedge clk);
    end
    checks++; if (nv != 1) $display("FAIL hold_idle_valids got %0d want 1", nv); else passes++;
    checks++; if (word !== 4'b1110) $display("FAIL hold_idle_word got %b want 1110", word); else passes++;
  endtask

  task automatic test_start_busy();
    int nv = 0;
    d_vec = 4'b1001;
    kick();
    for (int c = 1; c <= 16; c++) begin
      if (valid === 1'b1) begin
        nv++;
        checks++; if (c != 13) $display("FAIL busy_start_valid_cycle got %0d want 13", c); else passes++;
        checks++; if (word !== 4'b1001) $display("FAIL busy_start_word got %b want 1001", word); else passes++;
      end
      if (c == 14) begin
        checks++; if (busy !== 1'b0) $display("FAIL busy_start_idle_busy got %b want 0", busy); else passes++;
        checks++; if ({i1, i0} !== 2'b00) $display("FAIL busy_start_idle_sel got %b want 00", {i1, i0}); else passes++;
      end
      start = (c == 4 || c == 12);
      @(negedge clk);
    end
    start = 1'b0;
    checks++; if (nv != 1) $display("FAIL busy_start_valids got %0d want 1", nv); else passes++;
  endtask

  task automatic test_mid_reset();
    int nv = 0;
    d_vec = 4'b1111;
    kick();
    for (int c = 1; c <= 6; c++) begin
      if (valid === 1'b1) nv++;
      if (c == 6) rst = 1'b1;
      @(negedge clk);
    end
    checks++; if ({i1, i0} !== 2'b00) $display("FAIL midrst_sel got %b want 00", {i1, i0}); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", busy); else passes++;
    checks++; if (word !== 4'b0000) $display("FAIL midrst_word got %b want 0000", word); else passes++;
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (valid === 1'b1) nv++;
      @(negedge clk);
    end
    checks++; if (nv != 0) $display("FAIL midrst_valids got %0d want 0", nv); else passes++;
    checks++; if (word !== 4'b0000) $display("FAIL midrst_word_hold got %b want 0000", word); else passes++;
    kick();
    for (int c = 1; c <= 14; c++) begin
      if (valid === 1'b1) begin
        nv++;
        checks++; if (c != 13) $display("FAIL midrst_rescan_cycle got %0d want 13", c); else passes++;
        checks++; if (word !== 4'b1111) $display("FAIL midrst_rescan_word got %b want 1111", word); else passes++;
      end
      @(negedge clk);
    end
    checks++; if (nv != 1) $display("FAIL midrst_rescan_valids got %0d want 1", nv); else passes++;
  endtask

  task automatic test_continuous();
    int nv = 0;
    int last_v = 0;
    @(negedge clk);
    d2_vec = 4'b0011;
    rst2 = 1'b0;
    start2 = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (valid2 === 1'b1) begin
        nv++;
        checks++; if (word2 !== 4'b0011) $display("FAIL cont_word got %b want 0011", word2); else passes++;
        checks++;
        if (last_v == 0) begin
          if (n != 9) $display("FAIL cont_first_valid got cycle %0d want 9", n); else passes++;
        end else begin
          if (n - last_v != 10) $display("FAIL cont_period got %0d want 10", n - last_v); else passes++;
        end
        last_v = n;
      end
    end
    start2 = 1'b0;
    checks++; if (nv != 4) $display("FAIL cont_valids got %0d want 4", nv); else passes++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_word_hold();
    test_start_busy();
    test_mid_reset();
    test_continuous();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
